tmds_8b10b_encoder: RTL and testbench

TMDS_8B10B_ENCODER -- requirements
Module: tmds_8b10b_encoder

---
 rtl/tmds_8b10b_encoder.sv | 143 ++++++++++++++
 tb/tb_tmds_8b10b_encoder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_8b10b_encoder.sv
// TMDS 8b/10b channel encoder: video (DVI transition-minimised, DC-balanced), control,
// TERC4 data-island and video guard-band symbols, two-stage pipeline.
module tmds_8b10b_encoder #(
    parameter int CHANNEL = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] mode,
    input  logic [7:0] data,
    input  logic [1:0] ctrl,
    input  logic [3:0] terc4,
    output logic [9:0] out,
    output logic [4:0] disparity
);

    typedef enum logic [1:0] {
        MODE_CTRL  = 2'b00,
        MODE_VIDEO = 2'b01,
        MODE_TERC4 = 2'b10,
        MODE_GUARD = 2'b11
    } mode_t;

    localparam logic [9:0] CTRL_00 = 10'b1101010100;

    // Stage 1: transition minimisation
    logic [3:0] data_ones;
    logic       use_xnor;
    logic [8:0] qm_c;
    logic [3:0] qm_ones;

    always_comb begin
        data_ones = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            data_ones = data_ones + {3'b000, data[i]};
        end
        use_xnor = (data_ones > 4'd4) || ((data_ones == 4'd4) && !data[0]);
        qm_c     = '0;
        qm_c[0]  = data[0];
        for (int unsigned i = 1; i < 8; i++) begin
            qm_c[i] = use_xnor ? ~(qm_c[i-1] ^ data[i]) : (qm_c[i-1] ^ data[i]);
        end
        qm_c[8] = ~use_xnor;
        qm_ones = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            qm_ones = qm_ones + {3'b000, qm_c[i]};
        end
    end

    mode_t      s1_mode;
    logic [1:0] s1_ctrl;
    logic [3:0] s1_terc4;
    logic [8:0] s1_qm;
    logic [3:0] s1_n1q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_mode  <= MODE_CTRL;
            s1_ctrl  <= '0;
            s1_terc4 <= '0;
            s1_qm    <= '0;
            s1_n1q   <= '0;
        end else begin
            s1_mode  <= mode_t'(mode);
            s1_ctrl  <= ctrl;
            s1_terc4 <= terc4;
            s1_qm    <= qm_c;
            s1_n1q   <= qm_ones;
        end
    end

    // Stage 2: DC balancing and symbol selection; bal = n1q - n0q = 2*n1q - 8
    logic [9:0] out_c;
    logic [4:0] disp_c;
    logic [4:0] bal;
    logic       qm8;
    logic       disp_pos;
    logic       disp_neg;

    always_comb begin
        out_c    = CTRL_00;
        disp_c   = '0;
        qm8      = s1_qm[8];
        bal      = {s1_n1q, 1'b0} - 5'd8;
        disp_neg = disparity[4];
        disp_pos = !disparity[4] && (disparity != '0);
        case (s1_mode)
            MODE_VIDEO: begin
                if ((disparity == '0) || (s1_n1q == 4'd4)) begin
                    out_c  = {~qm8, qm8, qm8 ? s1_qm[7:0] : ~s1_qm[7:0]};
                    disp_c = qm8 ? disparity + bal : disparity - bal;
                end else if ((disp_pos && (s1_n1q > 4'd4)) || (disp_neg && (s1_n1q < 4'd4))) begin
                    out_c  = {1'b1, qm8, ~s1_qm[7:0]};
                    disp_c = disparity + {3'b000, qm8, 1'b0} - bal;
                end else begin
                    out_c  = {1'b0, qm8, s1_qm[7:0]};
                    disp_c = disparity - {3'b000, ~qm8, 1'b0} + bal;
                end
            end
            MODE_CTRL: begin
                case (s1_ctrl)
                    2'b00:   out_c = 10'b1101010100;
                    2'b01:   out_c = 10'b0010101011;
                    2'b10:   out_c = 10'b0101010100;
                    default: out_c = 10'b1010101011;
                endcase
            end
            MODE_TERC4: begin
                case (s1_terc4)
                    4'h0:    out_c = 10'b1010011100;
                    4'h1:    out_c = 10'b1001100011;
                    4'h2:    out_c = 10'b1011100100;
                    4'h3:    out_c = 10'b1011100010;
                    4'h4:    out_c = 10'b0101110001;
                    4'h5:    out_c = 10'b0100011110;
                    4'h6:    out_c = 10'b0110001110;
                    4'h7:    out_c = 10'b0100111100;
                    4'h8:    out_c = 10'b1011001100;
                    4'h9:    out_c = 10'b0100111001;
                    4'hA:    out_c = 10'b0110011100;
                    4'hB:    out_c = 10'b1011000110;
                    4'hC:    out_c = 10'b1010001110;
                    4'hD:    out_c = 10'b1001110001;
                    4'hE:    out_c = 10'b0101100011;
                    default: out_c = 10'b1011000011;
                endcase
            end
            default: begin
                out_c = (CHANNEL == 1) ? 10'b0100110011 : 10'b1011001100;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out       <= CTRL_00;
            disparity <= '0;
        end else begin
            out       <= out_c;
            disparity <= disp_c;
        end
    end

endmodule

// File: tb/tb_tmds_8b10b_encoder.sv
// Directed and randomised self-checking bench for tmds_8b10b_encoder (all three channels).
module tb_tmds_8b10b_encoder;

    logic       clk;
    logic       reset_n;
    logic [1:0] mode;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic [3:0] terc4;
    logic [9:0] out0, out1, out2;
    logic [4:0] disp0, disp1, disp2;

    int total = 0;
    int bad   = 0;

    logic [9:0] ctrl_tab [4]  = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    logic [9:0] terc_tab [16] = '{10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
                                  10'h2CC, 10'h139, 10'h19C, 10'h2C6, 10'h28E, 10'h271, 10'h163, 10'h2C3};

    tmds_8b10b_encoder #(.CHANNEL(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .mode(mode), .data(data), .ctrl(ctrl), .terc4(terc4),
        .out(out0), .disparity(disp0));
    tmds_8b10b_encoder #(.CHANNEL(1)) dut_g (
        .clk(clk), .reset_n(reset_n), .mode(mode), .data(data), .ctrl(ctrl), .terc4(terc4),
        .out(out1), .disparity(disp1));
    tmds_8b10b_encoder #(.CHANNEL(2)) dut_r (
        .clk(clk), .reset_n(reset_n), .mode(mode), .data(data), .ctrl(ctrl), .terc4(terc4),
        .out(out2), .disparity(disp2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Receiver-side TMDS video decode
    function automatic logic [7:0] tmds_decode(input logic [9:0] w);
        logic [7:0] d;
        logic [7:0] b;
        d = w[9] ? ~w[7:0] : w[7:0];
        b[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            b[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return b;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mode  = 2'($urandom_range(0, 3));
            data  = 8'($urandom_range(0, 255));
            ctrl  = 2'($urandom_range(0, 3));
            terc4 = 4'($urandom_range(0, 15));
            tick();
            total++;
            if (out0 !== 10'h354) begin
                bad++;
                $display("FAIL reset_hold_out: got %h want 354", out0);
            end
            total++;
            if (disp0 !== 5'd0) begin
                bad++;
                $display("FAIL reset_hold_disp: got %0d want 0", $signed(disp0));
            end
        end
        mode = 2'b00;
        ctrl = 2'b01;
        reset_n = 1'b1;
        #1;
        total++;
        if (out0 !== 10'h354) begin
            bad++;
            $display("FAIL reset_release_w0: got %h want 354", out0);
        end
        tick();
        ctrl = 2'b00;
        total++;
        if (out0 !== 10'h354) begin
            bad++;
            $display("FAIL reset_release_w1: got %h want 354", out0);
        end
        tick();
        total++;
        if (out0 !== 10'h0AB) begin
            bad++;
            $display("FAIL reset_release_first: got %h want 0ab", out0);
        end
    endtask

    task automatic test_control();
        logic [9:0] eo [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) begin
                mode = 2'b00;
                ctrl = 2'(i);
            end
            tick();
            if (i >= 1) begin
                total++;
                if (out0 !== eo[i-1] || disp0 !== 5'd0) begin
                    bad++;
                    $display("FAIL control[%0d]: got %h/%0d want %h/0", i - 1, out0, $signed(disp0), eo[i-1]);
                end
            end
        end
    endtask

    task automatic test_video_zero();
        logic [1:0] vm [8] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
        logic [9:0] eo [8] = '{10'h354, 10'h100, 10'h3FF, 10'h100, 10'h3FF, 10'h100, 10'h3FF, 10'h354};
        int         ed [8] = '{0, -8, 2, -6, 4, -4, 6, 0};
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                mode = vm[i];
                data = 8'h00;
                ctrl = 2'b00;
            end
            tick();
            if (i >= 1) begin
                total++;
                if (out0 !== eo[i-1] || disp0 !== 5'(ed[i-1])) begin
                    bad++;
                    $display("FAIL video_00[%0d]: got %h/%0d want %h/%0d", i - 1, out0, $signed(disp0), eo[i-1], ed[i-1]);
                end
            end
        end
    endtask

    task automatic test_video_ff();
        logic [1:0] vm [5] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01};
        logic [9:0] eo [5] = '{10'h354, 10'h200, 10'h0FF, 10'h0FF, 10'h200};
        int         ed [5] = '{0, -8, -2, 4, -4};
        for (int i = 0; i <= 5; i++) begin
            if (i < 5) begin
                mode = vm[i];
                data = 8'hFF;
                ctrl = 2'b00;
            end
            tick();
            if (i >= 1) begin
                total++;
                if (out0 !== eo[i-1] || disp0 !== 5'(ed[i-1])) begin
                    bad++;
                    $display("FAIL video_ff[%0d]: got %h/%0d want %h/%0d", i - 1, out0, $signed(disp0), eo[i-1], ed[i-1]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] vm [15] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
                                2'b01, 2'b01, 2'b01, 2'b11, 2'b01, 2'b10, 2'b00};
        logic [7:0] vd [15] = '{8'h00, 8'h0F, 8'hF0, 8'h55, 8'h01, 8'h80, 8'hAA, 8'hFE,
                                8'h01, 8'h00, 8'hFE, 8'h00, 8'hFF, 8'h00, 8'h00};
        logic [1:0] vc [15] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
                                2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3};
        logic [9:0] eo [15] = '{10'h354, 10'h105, 10'h0FA, 10'h133, 10'h1FF, 10'h180, 10'h233, 10'h2FF,
                                10'h300, 10'h100, 10'h2FF, 10'h2CC, 10'h200, 10'h11E, 10'h2AB};
        int         ed [15] = '{0, -4, -2, -2, 6, 0, 0, 8, 2, -6, 2, 0, -8, 0, 0};
        for (int i = 0; i <= 15; i++) begin
            if (i < 15) begin
                mode  = vm[i];
                data  = vd[i];
                ctrl  = vc[i];
                terc4 = 4'h5;
            end
            tick();
            if (i >= 1) begin
                total++;
                if (out0 !== eo[i-1] || disp0 !== 5'(ed[i-1])) begin
                    bad++;
                    $display("FAIL mixed[%0d]: got %h/%0d want %h/%0d", i - 1, out0, $signed(disp0), eo[i-1], ed[i-1]);
                end
            end
        end
    endtask

    task automatic test_terc4();
        logic [9:0] eo [16] = '{10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
                                10'h2CC, 10'h139, 10'h19C, 10'h2C6, 10'h28E, 10'h271, 10'h163, 10'h2C3};
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin
                mode  = 2'b10;
                terc4 = 4'(i);
            end
            tick();
            if (i >= 1) begin
                total++;
                if (out0 !== eo[i-1] || disp0 !== 5'd0) begin
                    bad++;
                    $display("FAIL terc4[%0h]: got %h/%0d want %h/0", i - 1, out0, $signed(disp0), eo[i-1]);
                end
            end
        end
    endtask

    task automatic test_guard();
        mode = 2'b01;
        data = 8'h00;
        tick();
        mode = 2'b11;
        tick();
        tick();
        total++;
        if (out0 !== 10'h2CC || disp0 !== 5'd0) begin
            bad++;
            $display("FAIL guard_ch0: got %h/%0d want 2cc/0", out0, $signed(disp0));
        end
        total++;
        if (out1 !== 10'h133 || disp1 !== 5'd0) begin
            bad++;
            $display("FAIL guard_ch1: got %h/%0d want 133/0", out1, $signed(disp1));
        end
        total++;
        if (out2 !== 10'h2CC || disp2 !== 5'd0) begin
            bad++;
            $display("FAIL guard_ch2: got %h/%0d want 2cc/0", out2, $signed(disp2));
        end
    endtask

    task automatic test_random();
        logic [1:0] pm;
        logic [7:0] pd;
        logic [1:0] pc;
        logic [3:0] pt;
        logic [9:0] want;
        int         sd;
        pm = 2'b00; pd = 8'h00; pc = 2'b00; pt = 4'h0;
        for (int i = 0; i < 20000; i++) begin
            mode  = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'($urandom_range(0, 3));
            data  = 8'($urandom_range(0, 255));
            ctrl  = 2'($urandom_range(0, 3));
            terc4 = 4'($urandom_range(0, 15));
            tick();
            if (i >= 1) begin
                sd = int'($signed(disp0));
                if (pm == 2'b01) begin
                    total++;
                    if (tmds_decode(out0) !== pd) begin
                        bad++;
                        $display("FAIL rand_video[%0d]: decoded %h want %h (word %h)", i, tmds_decode(out0), pd, out0);
                    end
                    total++;
                    if (sd < -10 || sd > 10 || disp0[0] !== 1'b0) begin
                        bad++;
                        $display("FAIL rand_disp[%0d]: got %0d want even within -10..10", i, sd);
                    end
                end else begin
                    want = (pm == 2'b00) ? ctrl_tab[pc] : (pm == 2'b10) ? terc_tab[pt] : 10'h2CC;
                    total++;
                    if (out0 !== want || disp0 !== 5'd0) begin
                        bad++;
                        $display("FAIL rand_nonvideo[%0d]: got %h/%0d want %h/0", i, out0, sd, want);
                    end
                end
            end
            pm = mode; pd = data; pc = ctrl; pt = terc4;
        end
    endtask

    task automatic test_reset_midstream();
        mode = 2'b01;
        data = 8'h0F;
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (out0 !== 10'h354 || disp0 !== 5'd0) begin
            bad++;
            $display("FAIL reset_async: got %h/%0d want 354/0", out0, $signed(disp0));
        end
        for (int i = 0; i < 2; i++) begin
            mode = 2'($urandom_range(0, 3));
            data = 8'($urandom_range(0, 255));
            tick();
            total++;
            if (out0 !== 10'h354 || disp0 !== 5'd0) begin
                bad++;
                $display("FAIL reset_mid_hold: got %h/%0d want 354/0", out0, $signed(disp0));
            end
        end
        mode = 2'b01;
        data = 8'h0F;
        reset_n = 1'b1;
        tick();
        mode = 2'b00;
        ctrl = 2'b00;
        total++;
        if (out0 !== 10'h354) begin
            bad++;
            $display("FAIL reset_mid_w1: got %h want 354", out0);
        end
        tick();
        total++;
        if (out0 !== 10'h105 || disp0 !== 5'(-4)) begin
            bad++;
            $display("FAIL reset_mid_first: got %h/%0d want 105/-4", out0, $signed(disp0));
        end
    endtask

    initial begin
        reset_n = 1'b0;
        mode    = 2'b00;
        data    = 8'h00;
        ctrl    = 2'b00;
        terc4   = 4'h0;
        test_reset();
        test_control();
        test_video_zero();
        test_video_ff();
        test_back_to_back();
        test_terc4();
        test_guard();
        test_random();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
